// File: rtl/seg7_pkg.sv
// Shared types for the seven-segment scan driver.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] nibble_t;

  function automatic nibble_t pick_nibble(input logic [15:0] value, input digit_idx_t idx);
    return value[4*idx +: 4];
  endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// Free-running divider producing a one-cycle TICK every SCAN_DIV clocks.
module seg7_prescaler #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic CLK,
  input  logic RESET_N,
  output logic TICK
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign TICK = (count == LAST);

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed scan driver with frame-aligned commit of new
// values and leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 100000,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] VALUE_IN,
  input  logic [3:0]  DOTS_IN,
  input  logic        LOAD_IN,
  input  logic        ENABLE_IN,
  output logic        BUSY_OUT,
  output logic [1:0]  DIGIT_SEL_OUT,
  output logic [3:0]  DIGIT_BIN_OUT,
  output logic        DIGIT_DOT_OUT,
  output logic        BLANK_OUT,
  output logic        FRAME_OUT
);

  logic        tick;
  digit_idx_t  digit_idx;
  digit_idx_t  next_idx;
  logic [15:0] shadow_val;
  logic [3:0]  shadow_dots;
  logic [15:0] active_val;
  logic [3:0]  active_dots;
  logic        pending;

  logic        wrap;
  logic        commit;
  logic [15:0] next_val;
  logic [3:0]  next_dots;
  logic [NUM_DIGITS-1:0] zero_from;
  logic        lz_blank;

  seg7_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .TICK    (tick)
  );

  // Outputs are computed from the value that will be active after this edge,
  // so a commit and the first display of digit 0 land on the same edge.
  always_comb begin
    next_idx  = digit_idx + digit_idx_t'(1);
    wrap      = tick && (digit_idx == digit_idx_t'(NUM_DIGITS - 1));
    commit    = wrap && pending;
    next_val  = commit ? shadow_val  : active_val;
    next_dots = commit ? shadow_dots : active_dots;
  end

  // zero_from[k]: nibbles and dots k..3 are all zero.
  always_comb begin
    logic run;
    run       = 1'b1;
    zero_from = '0;
    for (int unsigned i = NUM_DIGITS; i > 0; i--) begin
      run = run && (next_val[4*(i-1) +: 4] == '0) && !next_dots[i-1];
      zero_from[i-1] = run;
    end
    lz_blank = BLANK_LEADING && (next_idx != '0) && zero_from[next_idx];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      digit_idx     <= '0;
      shadow_val    <= '0;
      shadow_dots   <= '0;
      active_val    <= '0;
      active_dots   <= '0;
      pending       <= 1'b0;
      DIGIT_BIN_OUT <= '0;
      DIGIT_DOT_OUT <= 1'b0;
      BLANK_OUT     <= 1'b1;
      FRAME_OUT     <= 1'b0;
    end else begin
      if (LOAD_IN) begin
        shadow_val  <= VALUE_IN;
        shadow_dots <= DOTS_IN;
        pending     <= 1'b1;
      end else if (commit) begin
        pending     <= 1'b0;
      end
      if (commit) begin
        active_val  <= shadow_val;
        active_dots <= shadow_dots;
      end
      FRAME_OUT <= wrap;
      if (tick) begin
        digit_idx     <= next_idx;
        DIGIT_BIN_OUT <= pick_nibble(next_val, next_idx);
        DIGIT_DOT_OUT <= next_dots[next_idx];
        BLANK_OUT     <= lz_blank || !ENABLE_IN;
      end
    end
  end

  assign DIGIT_SEL_OUT = digit_idx;
  assign BUSY_OUT      = pending;

endmodule
